// File: rtl/adder_tree_pkg.sv
// Sizing helpers for the 1-bit population-count adder tree: result width,
// level count, and per-level element count / width / bit offset in a flat bus.
package adder_tree_pkg;

   function automatic int result_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

   function automatic int num_levels(input int n);
      return (n <= 1) ? 0 : $clog2(n);
   endfunction

   function automatic int level_elems(input int n, input int l);
      return (n + (1 << l) - 1) >> l;
   endfunction

   // Sums grow one bit per level but never beyond what the full count needs.
   function automatic int level_width(input int n, input int l);
      int w;
      int r;
      w = l + 1;
      r = result_width(n);
      return (w < r) ? w : r;
   endfunction

   function automatic int level_offset(input int n, input int l);
      int off;
      off = 0;
      for (int k = 0; k < l; k++) begin
         off += level_elems(n, k) * level_width(n, k);
      end
      return off;
   endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One level of the popcount tree: adds adjacent pairs (2k, 2k+1) and passes an
// odd leftover element through zero-extended. Purely combinational.
module adder_tree_level #(
   parameter int IN_CNT = 8,
   parameter int IN_W   = 1,
   parameter int OUT_W  = 2
) (
   input  logic [IN_CNT*IN_W-1:0]            in_i,
   output logic [((IN_CNT+1)/2)*OUT_W-1:0]   sum_o
);

   localparam int PAIRS = IN_CNT / 2;

   for (genvar k = 0; k < PAIRS; k++) begin : g_pair
      assign sum_o[k*OUT_W +: OUT_W] = OUT_W'(in_i[(2*k)*IN_W +: IN_W])
                                     + OUT_W'(in_i[(2*k+1)*IN_W +: IN_W]);
   end

   if ((IN_CNT % 2) == 1) begin : g_odd
      assign sum_o[PAIRS*OUT_W +: OUT_W] = OUT_W'(in_i[(IN_CNT-1)*IN_W +: IN_W]);
   end

endmodule

// File: rtl/adder_tree_1bit.sv
// Registered popcount of an N-bit vector via a balanced adder tree.
// Define ADDER_TREE_1BIT_PIPE_EN to register every tree level (latency L+1).
module adder_tree_1bit
   import adder_tree_pkg::*;
#(
   parameter int N = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         valid_in,
   input  logic [N-1:0]                 vector,
   output logic                         valid_out,
   output logic [result_width(N)-1:0]   result
);

   localparam int RW  = result_width(N);
   localparam int L   = num_levels(N);
   localparam int TBW = level_offset(N, L + 1);
   localparam int FO  = level_offset(N, L);
   localparam int FW  = level_width(N, L);

`ifdef ADDER_TREE_1BIT_PIPE_EN
   localparam int VD = L + 1;
`else
   localparam int VD = 1;
`endif

   // Every level's elements live back to back in one flat bus; level 0 is the raw vector.
   logic [TBW-1:0] tree_w;
   logic [RW-1:0]  result_d;
   logic [RW-1:0]  result_q;
   logic [VD-1:0]  vld_d;
   logic [VD-1:0]  vld_q;

   assign tree_w[N-1:0] = vector;

   for (genvar g = 0; g < L; g++) begin : g_level
      localparam int IO = level_offset(N, g);
      localparam int IC = level_elems(N, g);
      localparam int IW = level_width(N, g);
      localparam int OO = level_offset(N, g + 1);
      localparam int OC = level_elems(N, g + 1);
      localparam int OW = level_width(N, g + 1);

      logic [OC*OW-1:0] sum_w;

      adder_tree_level #(
         .IN_CNT (IC),
         .IN_W   (IW),
         .OUT_W  (OW)
      ) u_level (
         .in_i  (tree_w[IO +: IC*IW]),
         .sum_o (sum_w)
      );

`ifdef ADDER_TREE_1BIT_PIPE_EN
      logic [OC*OW-1:0] stage_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            stage_q <= '0;
         end else begin
            stage_q <= sum_w;
         end
      end

      assign tree_w[OO +: OC*OW] = stage_q;
`else
      assign tree_w[OO +: OC*OW] = sum_w;
`endif
   end

   assign result_d = RW'(tree_w[FO +: FW]);

   // valid rides a shift chain exactly as deep as the data path.
   if (VD == 1) begin : g_vld_single
      assign vld_d = valid_in;
   end else begin : g_vld_chain
      assign vld_d = {vld_q[VD-2:0], valid_in};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= '0;
         vld_q    <= '0;
      end else begin
         result_q <= result_d;
         vld_q    <= vld_d;
      end
   end

   assign result    = result_q;
   assign valid_out = vld_q[VD-1];

endmodule

// File: tb/tb_adder_tree_1bit.sv
// Scoreboard bench for adder_tree_1bit: N=8, N=5 and N=1 instances share one stimulus stream.
module tb_adder_tree_1bit;

`ifdef ADDER_TREE_1BIT_PIPE_EN
   localparam int LAT8 = 4;
   localparam int LAT5 = 4;
   localparam int LAT1 = 1;
`else
   localparam int LAT8 = 1;
   localparam int LAT5 = 1;
   localparam int LAT1 = 1;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       valid_in = 1'b0;
   logic [7:0] vec8 = '0;
   logic [4:0] vec5 = '0;
   logic [0:0] vec1 = '0;
   logic       vo8, vo5, vo1;
   logic [3:0] res8;
   logic [2:0] res5;
   logic [0:0] res1;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [3:0] exp8_q[$];
   logic [2:0] exp5_q[$];
   logic [0:0] exp1_q[$];
   int         cyc8_q[$];
   int         cyc5_q[$];
   int         cyc1_q[$];

   adder_tree_1bit #(.N(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .vector(vec8),
      .valid_out(vo8), .result(res8));
   adder_tree_1bit #(.N(5)) u_dut5 (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .vector(vec5),
      .valid_out(vo5), .result(res5));
   adder_tree_1bit #(.N(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .vector(vec1),
      .valid_out(vo1), .result(res1));

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic flag_unexpected(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=valid_out_high expected=no_pending_result (t=%0t)", name, $time);
   endtask

   task automatic push_exp(input logic [7:0] v8, input logic [3:0] e8);
      exp8_q.push_back(e8);
      exp5_q.push_back(3'($countones(v8[4:0])));
      exp1_q.push_back(v8[0]);
      cyc8_q.push_back(cyc);
      cyc5_q.push_back(cyc);
      cyc1_q.push_back(cyc);
   endtask

   task automatic send(input logic [7:0] v8, input logic [3:0] e8, input logic vld);
      @(posedge clk);
      #1;
      vec8     = v8;
      vec5     = v8[4:0];
      vec1     = v8[0];
      valid_in = vld;
      if (vld) push_exp(v8, e8);
   endtask

   // monitors
   always @(negedge clk) begin
      if (rst_n && vo8) begin
         if (exp8_q.size() == 0) flag_unexpected("stale8");
         else begin
            check("result8", res8, exp8_q.pop_front());
            check("latency8", cyc - cyc8_q.pop_front(), LAT8);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && vo5) begin
         if (exp5_q.size() == 0) flag_unexpected("stale5");
         else begin
            check("result5", res5, exp5_q.pop_front());
            check("latency5", cyc - cyc5_q.pop_front(), LAT5);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && vo1) begin
         if (exp1_q.size() == 0) flag_unexpected("stale1");
         else begin
            check("result1", res1, exp1_q.pop_front());
            check("latency1", cyc - cyc1_q.pop_front(), LAT1);
         end
      end
   end

   // directed vectors with hand-computed N=8 counts
   logic [7:0] dir_v [12] = '{8'h00, 8'hFF, 8'h01, 8'h0F, 8'hAA, 8'h80,
                              8'h17, 8'h1F, 8'h3C, 8'h55, 8'h7F, 8'hFE};
   logic [3:0] dir_e [12] = '{4'd0, 4'd8, 4'd1, 4'd4, 4'd4, 4'd1,
                              4'd4, 4'd5, 4'd4, 4'd4, 4'd7, 4'd7};

   initial begin
      // reset held with an all-ones valid input
      vec8 = 8'hFF; vec5 = 5'h1F; vec1 = 1'b1; valid_in = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_result8", res8, 0);
      check("rst_valid8", vo8, 0);
      check("rst_result5", res5, 0);
      check("rst_valid5", vo5, 0);
      check("rst_result1", res1, 0);
      check("rst_valid1", vo1, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      push_exp(8'hFF, 4'd8);

      for (int i = 0; i < 12; i++) send(dir_v[i], dir_e[i], 1'b1);
      send(8'hFF, 4'd8, 1'b0);
      send(8'h0F, 4'd4, 1'b1);
      send(8'hF0, 4'd4, 1'b0);
      send(8'h81, 4'd2, 1'b1);
      send(8'h00, 4'd0, 1'b0);

      // reset between edges with results in flight
      send(8'h01, 4'd1, 1'b1);
      send(8'h0F, 4'd4, 1'b1);
      send(8'hAA, 4'd4, 1'b1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      valid_in = 1'b0;
      exp8_q.delete(); exp5_q.delete(); exp1_q.delete();
      cyc8_q.delete(); cyc5_q.delete(); cyc1_q.delete();
      #1;
      check("midrst_result8", res8, 0);
      check("midrst_valid8", vo8, 0);
      check("midrst_result5", res5, 0);
      check("midrst_valid5", vo5, 0);
      check("midrst_result1", res1, 0);
      check("midrst_valid1", vo1, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (6) send(8'hFF, 4'd8, 1'b0);
      send(8'h80, 4'd1, 1'b1);
      send(8'h17, 4'd4, 1'b1);

      // random stream with random valid_in
      for (int i = 0; i < 300; i++) begin
         logic [7:0] v;
         v = 8'($urandom_range(0, 255));
         send(v, 4'($countones(v)), 1'($urandom_range(0, 1)));
      end

      // drain
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      repeat (LAT8 + 4) @(posedge clk);
      @(negedge clk);
      check("drain8", exp8_q.size(), 0);
      check("drain5", exp5_q.size(), 0);
      check("drain1", exp1_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/adder_tree_1bit.md
Name: adder_tree_1bit

Overview:
- Population-count reduction: sums N single-bit inputs into an unsigned count using a balanced binary adder tree.
- Used by the filter/reduce stage. One instance per output lane counts the filter hits of one row of the N×N reduce matrix.
- Result is registered.
- A pipeline macro trades latency for timing.

Parameters:
- N, 8, number of 1-bit inputs (≥1).
- RESULT_WIDTH, $clog2(N+1) (derived localparam, not overridable), width of the count. Holds the full range 0..N.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- valid_in  input  1  qualifies vector on this cycle.
- vector  input  N  bits to count. Bit i is lane i; lane order is irrelevant to the result.
- valid_out  output  1  result is valid.
- result  output  RESULT_WIDTH  number of ones in the sampled vector.

Behaviour:
- Reset: rst_n low asynchronously clears result to 0, valid_out to 0, and all internal pipeline registers and their valid bits to 0.
- Reset release: registers resume capture on the first rising edge with rst_n high.
- Arithmetic: result = popcount(vector), unsigned, no overflow possible.
- Tree structure:
  - Level 0 = N values of width 1.
  - Each level adds adjacent pairs (2k, 2k+1); each sum is one bit wider than its operands, capped at RESULT_WIDTH.
  - An odd leftover element passes to the next level unchanged, zero-extended.
  - Number of levels L = ceil(log2 N); L = 0 when N = 1, in which case result = vector[0].
- Zero-extend every operand to RESULT_WIDTH before the final stage.
- Without the macro: tree is combinational; the output register captures the sum and valid_in every cycle. Latency is exactly 1 cycle.
- No stall or enable. Data is captured every cycle regardless of valid_in; valid_in only travels alongside as valid_out.
- Back-to-back vectors produce back-to-back results, throughput 1 per cycle.
- valid_in low: result still updates with the popcount of vector (don't-care to consumers); valid_out = 0.
- Reset mid-stream: all in-flight results are discarded, and valid_out stays 0 until new valid inputs have traversed the full latency.

Optional Feature:
- Macro: ADDER_TREE_1BIT_PIPE_EN.
- Defined:
  - A register stage follows every tree level, in addition to the output register.
  - Latency = L+1 cycles (N=8 → 4; N=1 → 1).
  - valid is delayed in lockstep through an identical shift chain.
  - Throughput is still 1 per cycle.
  - All stage registers reset asynchronously to 0.
- Undefined: latency is 1 cycle as above.
- Function is identical in both builds, only delayed.

Decomposition:
- Package adder_tree_pkg:
  - function returning RESULT_WIDTH for a given N.
  - function returning level count L for a given N.
  - function returning element count at level l: ceil(N/2^l).
- One natural sub-module: adder_tree_level.
  - Parameters: input count, input width.
  - Behaviour: pairwise adds one level, with odd-element passthrough.
  - Instantiated L times from a generate loop; registered per stage only when the macro is defined.

Test Plan:
- Reset: hold rst_n=0 with vector=8'hFF, valid_in=1 → result=0, valid_out=0. Release and apply the same input → after the latency, result=8, valid_out=1.
- Extremes, N=8: vector=8'h00 → 0; 8'hFF → 8 (4'b1000, no overflow).
- Streaming, N=8: vectors 8'h01, 8'h0F, 8'hAA, 8'h80 on consecutive cycles with valid_in=1 → results 1, 4, 4, 1 on consecutive cycles after the latency, valid_out continuously 1.
- Odd and edge widths:
  - N=5, vector=5'b10111 → 4; 5'b11111 → 5 (RESULT_WIDTH=3).
  - N=1, vector=1 → 1.
- Async reset mid-stream: drop rst_n between clock edges while valid results are in flight → result=0 and valid_out=0 immediately. No stale result appears after release.
- Exhaustive random, both macro settings: N∈{1,3,8,16}, 1000 random vectors with random valid_in → result equals the reference popcount. valid_out equals valid_in delayed by exactly 1 (macro off) or L+1 (macro on) cycles.
